// File: rtl/core_dbg_regs.sv
// Debug register file and core-control sequencer behind the core-debug APB slave.
// Define CORE_DBG_BKPT_EN to add the breakpoint address/enable registers and ports.
`timescale 1ns/1ps
module core_dbg_regs #(
  parameter int unsigned ADDR_WIDTH    = 5,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned GPR_IDX_WIDTH = 5,
  parameter int unsigned TIMEOUT       = 255,
  parameter logic [31:0] DBG_ID        = 32'hDC00_0001
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     core_dbg_req,
  input  logic                     core_dbg_wr_rd,
  input  logic [ADDR_WIDTH-1:0]    core_dbg_addr,
  input  logic [DATA_WIDTH-1:0]    core_dbg_wdata,
  output logic [DATA_WIDTH-1:0]    core_dbg_rdata,
  output logic                     core_dbg_rd_ready,
  output logic                     halt_req,
  output logic                     resume_req,
  output logic                     step_req,
  input  logic                     core_halted,
`ifdef CORE_DBG_BKPT_EN
  output logic [DATA_WIDTH-1:0]    bkpt_addr,
  output logic                     bkpt_en,
  input  logic                     bkpt_hit,
`endif
  output logic                     gpr_req,
  output logic                     gpr_we,
  output logic [GPR_IDX_WIDTH-1:0] gpr_idx,
  output logic [DATA_WIDTH-1:0]    gpr_wdata,
  input  logic                     gpr_ack,
  input  logic [DATA_WIDTH-1:0]    gpr_rdata
);

  localparam logic [ADDR_WIDTH-1:0] AddrCtrl    = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] AddrStatus  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] AddrGprIdx  = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] AddrGprData = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] AddrGprCmd  = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] AddrId      = ADDR_WIDTH'(31);
`ifdef CORE_DBG_BKPT_EN
  localparam logic [ADDR_WIDTH-1:0] AddrBkptAddr = ADDR_WIDTH'(5);
  localparam logic [ADDR_WIDTH-1:0] AddrBkptCtrl = ADDR_WIDTH'(6);
`endif
  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  typedef enum logic {GIdle, GWait} gpr_state_e;
  typedef enum logic [1:0] {RIdle, RWait, RResp} rd_state_e;

  gpr_state_e gpr_state_q, gpr_state_d;
  rd_state_e  rd_state_q, rd_state_d;

  logic                     halt_q, halt_d, resume_q, resume_d, step_q, step_d;
  logic                     seen_q, seen_d, err_q, err_d;
  logic [GPR_IDX_WIDTH-1:0] idx_reg_q, idx_reg_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic                     req_q, req_d, we_q, we_d;
  logic [GPR_IDX_WIDTH-1:0] idx_out_q, idx_out_d;
  logic [DATA_WIDTH-1:0]    wdata_out_q, wdata_out_d;
  logic [7:0]               cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]    rd_addr_q, rd_addr_d;
  logic [DATA_WIDTH-1:0]    status, rd_mux;

  logic wr_en, rd_en, ctrl_wr, idx_wr, data_wr, cmd_wr, cmd_rw, cmd_clr;
  logic gpr_busy, gpr_done, bkpt_trig;

  assign wr_en   = core_dbg_req & core_dbg_wr_rd;
  assign rd_en   = core_dbg_req & ~core_dbg_wr_rd;
  assign ctrl_wr = wr_en && (core_dbg_addr == AddrCtrl);
  assign idx_wr  = wr_en && (core_dbg_addr == AddrGprIdx);
  assign data_wr = wr_en && (core_dbg_addr == AddrGprData);
  assign cmd_wr  = wr_en && (core_dbg_addr == AddrGprCmd);
  assign cmd_rw  = cmd_wr && ((core_dbg_wdata == DATA_WIDTH'(1)) ||
                              (core_dbg_wdata == DATA_WIDTH'(2)));
  assign cmd_clr = cmd_wr && (core_dbg_wdata == DATA_WIDTH'(3));

  assign gpr_busy = (gpr_state_q == GWait);
  // Access finishes on this edge: lets a waiting read respond with no extra bubble.
  assign gpr_done = gpr_busy && (gpr_ack || (cnt_q == CntLast));

`ifdef CORE_DBG_BKPT_EN
  logic [DATA_WIDTH-1:0] bkpt_addr_q;
  logic                  bkpt_en_q, bkpt_seen_q;
  assign bkpt_trig = bkpt_hit & bkpt_en_q;
  assign bkpt_addr = bkpt_addr_q;
  assign bkpt_en   = bkpt_en_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bkpt_addr_q <= '0;
      bkpt_en_q   <= 1'b0;
      bkpt_seen_q <= 1'b0;
    end else begin
      if (wr_en && (core_dbg_addr == AddrBkptAddr)) bkpt_addr_q <= core_dbg_wdata;
      if (wr_en && (core_dbg_addr == AddrBkptCtrl)) bkpt_en_q <= core_dbg_wdata[0];
      if (cmd_clr && !gpr_busy) bkpt_seen_q <= 1'b0;
      else if (bkpt_trig)       bkpt_seen_q <= 1'b1;
    end
  end
`else
  assign bkpt_trig = 1'b0;
`endif

  // Core control handshakes and sticky status.
  always_comb begin
    halt_d   = halt_q;
    resume_d = resume_q;
    seen_d   = seen_q;
    if (core_halted) halt_d = 1'b0;
    if ((ctrl_wr && core_dbg_wdata[0]) || bkpt_trig) halt_d = 1'b1;
    if (!core_halted) resume_d = 1'b0;
    if (ctrl_wr && core_dbg_wdata[1] && !core_dbg_wdata[0] && core_halted) resume_d = 1'b1;
    step_d = ctrl_wr && core_dbg_wdata[2] && core_halted;
    if (core_halted) seen_d = 1'b1;
    if (cmd_clr && !gpr_busy) seen_d = 1'b0;
  end

  // GPR access sequencer.
  always_comb begin
    gpr_state_d = gpr_state_q;
    req_d       = req_q;
    we_d        = we_q;
    idx_out_d   = idx_out_q;
    wdata_out_d = wdata_out_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    err_d       = err_q;
    idx_reg_d   = idx_reg_q;
    if (idx_wr) idx_reg_d = core_dbg_wdata[GPR_IDX_WIDTH-1:0];
    if (data_wr) begin
      if (gpr_busy) err_d = 1'b1;
      else          data_d = core_dbg_wdata;
    end
    if (cmd_wr && gpr_busy) err_d = 1'b1;
    case (gpr_state_q)
      GIdle: begin
        if (cmd_rw) begin
          if (core_halted) begin
            idx_out_d   = idx_reg_q;
            we_d        = core_dbg_wdata[1];
            wdata_out_d = data_q;
            req_d       = 1'b1;
            cnt_d       = '0;
            gpr_state_d = GWait;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      GWait: begin
        if (gpr_ack) begin
          req_d       = 1'b0;
          if (!we_q) data_d = gpr_rdata;
          gpr_state_d = GIdle;
        end else if (cnt_q == CntLast) begin
          req_d       = 1'b0;
          err_d       = 1'b1;
          gpr_state_d = GIdle;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: gpr_state_d = GIdle;
    endcase
    if (cmd_clr && !gpr_busy) err_d = 1'b0;
  end

  // Read response sequencer.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_addr_d  = rd_addr_q;
    case (rd_state_q)
      RIdle: begin
        if (rd_en) begin
          rd_addr_d = core_dbg_addr;
          if ((core_dbg_addr == AddrGprData) && gpr_busy && !gpr_done) rd_state_d = RWait;
          else                                                         rd_state_d = RResp;
        end
      end
      RWait:   if (!gpr_busy || gpr_done) rd_state_d = RResp;
      RResp:   rd_state_d = RIdle;
      default: rd_state_d = RIdle;
    endcase
  end

  always_comb begin
    status    = '0;
    status[0] = core_halted;
    status[1] = gpr_busy;
    status[2] = err_q;
    status[3] = seen_q;
`ifdef CORE_DBG_BKPT_EN
    status[4] = bkpt_seen_q;
`endif
    rd_mux = '0;
    case (rd_addr_q)
      AddrStatus:   rd_mux = status;
      AddrGprIdx:   rd_mux = DATA_WIDTH'(idx_reg_q);
      AddrGprData:  rd_mux = data_q;
      AddrId:       rd_mux = DATA_WIDTH'(DBG_ID);
`ifdef CORE_DBG_BKPT_EN
      AddrBkptAddr: rd_mux = bkpt_addr_q;
      AddrBkptCtrl: rd_mux = DATA_WIDTH'(bkpt_en_q);
`endif
      default:      rd_mux = '0;
    endcase
  end

  assign core_dbg_rd_ready = (rd_state_q == RResp);
  assign core_dbg_rdata    = core_dbg_rd_ready ? rd_mux : '0;
  assign halt_req          = halt_q;
  assign resume_req        = resume_q;
  assign step_req          = step_q;
  assign gpr_req           = req_q;
  assign gpr_we            = we_q;
  assign gpr_idx           = idx_out_q;
  assign gpr_wdata         = wdata_out_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gpr_state_q <= GIdle;
      rd_state_q  <= RIdle;
      halt_q      <= 1'b0;
      resume_q    <= 1'b0;
      step_q      <= 1'b0;
      seen_q      <= 1'b0;
      err_q       <= 1'b0;
      idx_reg_q   <= '0;
      data_q      <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      idx_out_q   <= '0;
      wdata_out_q <= '0;
      cnt_q       <= '0;
      rd_addr_q   <= '0;
    end else begin
      gpr_state_q <= gpr_state_d;
      rd_state_q  <= rd_state_d;
      halt_q      <= halt_d;
      resume_q    <= resume_d;
      step_q      <= step_d;
      seen_q      <= seen_d;
      err_q       <= err_d;
      idx_reg_q   <= idx_reg_d;
      data_q      <= data_d;
      req_q       <= req_d;
      we_q        <= we_d;
      idx_out_q   <= idx_out_d;
      wdata_out_q <= wdata_out_d;
      cnt_q       <= cnt_d;
      rd_addr_q   <= rd_addr_d;
    end
  end

endmodule

// File: tb/tb_core_dbg_regs.sv
// Directed self-checking bench for core_dbg_regs (default build, breakpoint feature off).
`timescale 1ns/1ps
module tb_core_dbg_regs;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        core_dbg_req = 1'b0;
  logic        core_dbg_wr_rd = 1'b0;
  logic [4:0]  core_dbg_addr = '0;
  logic [31:0] core_dbg_wdata = '0;
  logic [31:0] core_dbg_rdata;
  logic        core_dbg_rd_ready;
  logic        halt_req, resume_req, step_req;
  logic        core_halted = 1'b0;
  logic        gpr_req, gpr_we;
  logic [4:0]  gpr_idx;
  logic [31:0] gpr_wdata;
  logic        gpr_ack = 1'b0;
  logic [31:0] gpr_rdata = '0;

  int total = 0;
  int bad = 0;
  logic rd_outstanding = 1'b0;

  core_dbg_regs dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .core_dbg_req     (core_dbg_req),
    .core_dbg_wr_rd   (core_dbg_wr_rd),
    .core_dbg_addr    (core_dbg_addr),
    .core_dbg_wdata   (core_dbg_wdata),
    .core_dbg_rdata   (core_dbg_rdata),
    .core_dbg_rd_ready(core_dbg_rd_ready),
    .halt_req         (halt_req),
    .resume_req       (resume_req),
    .step_req         (step_req),
    .core_halted      (core_halted),
    .gpr_req          (gpr_req),
    .gpr_we           (gpr_we),
    .gpr_idx          (gpr_idx),
    .gpr_wdata        (gpr_wdata),
    .gpr_ack          (gpr_ack),
    .gpr_rdata        (gpr_rdata)
  );

  always #5 clk = ~clk;

  // Upstream must never issue a request while a read is still in flight.
  always @(posedge clk) begin
    if (core_dbg_req) assert (!rd_outstanding) else $error("FAIL req_overlap req while read pending");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    core_dbg_req = 1'b1; core_dbg_wr_rd = 1'b1; core_dbg_addr = a; core_dbg_wdata = d;
    tick();
    core_dbg_req = 1'b0; core_dbg_wr_rd = 1'b0;
  endtask

  // ok = rd_ready high for the response cycle, then rd_ready and rdata both 0.
  task automatic rd(input logic [4:0] a, output logic [31:0] d, output logic ok);
    core_dbg_req = 1'b1; core_dbg_wr_rd = 1'b0; core_dbg_addr = a;
    tick();
    core_dbg_req = 1'b0;
    rd_outstanding = 1'b1;
    ok = (core_dbg_rd_ready === 1'b1);
    d  = core_dbg_rdata;
    tick();
    ok = ok && (core_dbg_rd_ready === 1'b0) && (core_dbg_rdata === 32'h0);
    rd_outstanding = 1'b0;
  endtask

  task automatic test_reset();
    logic [73:0] outs;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    outs = {core_dbg_rdata, core_dbg_rd_ready, halt_req, resume_req, step_req,
            gpr_req, gpr_we, gpr_idx, gpr_wdata};
    total++;
    if (outs !== '0) begin
      bad++; $display("FAIL reset_outputs got=%h exp=0", outs);
    end
  endtask

  task automatic test_id_read();
    logic [31:0] d; logic ok;
    rd(5'd31, d, ok);
    total++;
    if (!ok || d !== 32'hDC00_0001) begin
      bad++; $display("FAIL id_read got=%h ok=%0b exp=dc000001", d, ok);
    end
    wr(5'd5, 32'h1234_5678);
    rd(5'd5, d, ok);
    total++;
    if (!ok || d !== 32'h0) begin
      bad++; $display("FAIL unmapped5_read got=%h ok=%0b exp=0", d, ok);
    end
    rd(5'd0, d, ok);
    total++;
    if (!ok || d !== 32'h0) begin
      bad++; $display("FAIL ctrl_read got=%h ok=%0b exp=0", d, ok);
    end
  endtask

  task automatic test_gpr_idx_reg();
    logic [31:0] d; logic ok;
    wr(5'd2, 32'hFFFF_FFE3);
    rd(5'd2, d, ok);
    total++;
    if (!ok || d !== 32'h3) begin
      bad++; $display("FAIL gpr_idx_mask got=%h ok=%0b exp=3", d, ok);
    end
  endtask

  task automatic test_halt();
    logic [31:0] d; logic ok;
    wr(5'd0, 32'h1);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (halt_req !== 1'b1) begin
        bad++; $display("FAIL halt_hold cycle=%0d got=%b exp=1", i, halt_req);
      end
      if (i == 4) core_halted = 1'b1;
      tick();
    end
    total++;
    if (halt_req !== 1'b0) begin
      bad++; $display("FAIL halt_clear got=%b exp=0", halt_req);
    end
    rd(5'd1, d, ok);
    total++;
    if (!ok || d !== 32'h9) begin
      bad++; $display("FAIL status_halted got=%h ok=%0b exp=9", d, ok);
    end
    wr(5'd0, 32'h4);
    total++;
    if (step_req !== 1'b1) begin
      bad++; $display("FAIL step_pulse got=%b exp=1", step_req);
    end
    tick();
    total++;
    if (step_req !== 1'b0) begin
      bad++; $display("FAIL step_end got=%b exp=0", step_req);
    end
    wr(5'd0, 32'h3);
    total++;
    if (resume_req !== 1'b0 || halt_req !== 1'b1) begin
      bad++; $display("FAIL halt_wins got=%b%b exp=01", resume_req, halt_req);
    end
    tick();
  endtask

  task automatic test_gpr_read();
    logic [31:0] d; logic ok;
    wr(5'd2, 32'd7);
    wr(5'd4, 32'd1);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (gpr_req !== 1'b1 || gpr_idx !== 5'd7 || gpr_we !== 1'b0) begin
        bad++; $display("FAIL gpr_rd_req cycle=%0d got=%b/%0d/%b exp=1/7/0", i, gpr_req, gpr_idx, gpr_we);
      end
      if (i == 2) begin gpr_ack = 1'b1; gpr_rdata = 32'hCAFE_F00D; end
      tick();
    end
    gpr_ack = 1'b0;
    total++;
    if (gpr_req !== 1'b0) begin
      bad++; $display("FAIL gpr_rd_drop got=%b exp=0", gpr_req);
    end
    rd(5'd3, d, ok);
    total++;
    if (!ok || d !== 32'hCAFE_F00D) begin
      bad++; $display("FAIL gpr_data_read got=%h ok=%0b exp=cafef00d", d, ok);
    end
  endtask

  task automatic test_rd_wait();
    wr(5'd2, 32'd3);
    wr(5'd4, 32'd1);
    core_dbg_req = 1'b1; core_dbg_wr_rd = 1'b0; core_dbg_addr = 5'd3;
    tick();
    core_dbg_req = 1'b0;
    rd_outstanding = 1'b1;
    for (int i = 0; i < 10; i++) begin
      total++;
      if (core_dbg_rd_ready !== 1'b0) begin
        bad++; $display("FAIL rd_withheld cycle=%0d got=%b exp=0", i, core_dbg_rd_ready);
      end
      if (i == 9) begin gpr_ack = 1'b1; gpr_rdata = 32'h1234_5678; end
      tick();
    end
    gpr_ack = 1'b0;
    total++;
    if (core_dbg_rd_ready !== 1'b1 || core_dbg_rdata !== 32'h1234_5678) begin
      bad++; $display("FAIL rd_after_ack got=%b/%h exp=1/12345678", core_dbg_rd_ready, core_dbg_rdata);
    end
    tick();
    rd_outstanding = 1'b0;
    total++;
    if (core_dbg_rd_ready !== 1'b0 || core_dbg_rdata !== 32'h0) begin
      bad++; $display("FAIL rd_after_ack_end got=%b/%h exp=0/0", core_dbg_rd_ready, core_dbg_rdata);
    end
  endtask

  task automatic test_resume_and_err();
    logic [31:0] d; logic ok; int cnt;
    wr(5'd0, 32'h2);
    total++;
    if (resume_req !== 1'b1) begin
      bad++; $display("FAIL resume_set got=%b exp=1", resume_req);
    end
    core_halted = 1'b0;
    tick();
    total++;
    if (resume_req !== 1'b0) begin
      bad++; $display("FAIL resume_clear got=%b exp=0", resume_req);
    end
    wr(5'd0, 32'h2);
    wr(5'd4, 32'd2);
    total++;
    if (resume_req !== 1'b0 || gpr_req !== 1'b0) begin
      bad++; $display("FAIL not_halted_ignored got=%b/%b exp=0/0", resume_req, gpr_req);
    end
    rd(5'd1, d, ok);
    total++;
    if (!ok || d !== 32'hC) begin
      bad++; $display("FAIL status_err got=%h ok=%0b exp=c", d, ok);
    end
    wr(5'd4, 32'd3);
    rd(5'd1, d, ok);
    total++;
    if (!ok || d !== 32'h0) begin
      bad++; $display("FAIL status_cleared got=%h ok=%0b exp=0", d, ok);
    end
    core_halted = 1'b1;
    wr(5'd4, 32'd2);
    total++;
    if (gpr_we !== 1'b1 || gpr_wdata !== 32'h1234_5678 || gpr_idx !== 5'd3) begin
      bad++; $display("FAIL gpr_wr_fields got=%b/%h/%0d exp=1/12345678/3", gpr_we, gpr_wdata, gpr_idx);
    end
    cnt = 0;
    while (gpr_req === 1'b1 && cnt < 300) begin
      cnt++;
      tick();
    end
    total++;
    if (cnt != 255) begin
      bad++; $display("FAIL timeout_len got=%0d exp=255", cnt);
    end
    rd(5'd1, d, ok);
    total++;
    if (!ok || d !== 32'hD) begin
      bad++; $display("FAIL status_timeout got=%h ok=%0b exp=d", d, ok);
    end
    wr(5'd4, 32'd3);
    rd(5'd1, d, ok);
    total++;
    if (!ok || d !== 32'h9) begin
      bad++; $display("FAIL status_clr2 got=%h ok=%0b exp=9", d, ok);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic ok; logic [73:0] outs;
    wr(5'd0, 32'h2);
    wr(5'd4, 32'd1);
    total++;
    if (gpr_req !== 1'b1 || resume_req !== 1'b1) begin
      bad++; $display("FAIL pre_reset_busy got=%b/%b exp=1/1", gpr_req, resume_req);
    end
    rst_n = 1'b0;
    tick();
    outs = {core_dbg_rdata, core_dbg_rd_ready, halt_req, resume_req, step_req,
            gpr_req, gpr_we, gpr_idx, gpr_wdata};
    total++;
    if (outs !== '0) begin
      bad++; $display("FAIL reset_mid_outputs got=%h exp=0", outs);
    end
    rst_n = 1'b1;
    tick();
    rd(5'd31, d, ok);
    total++;
    if (!ok || d !== 32'hDC00_0001) begin
      bad++; $display("FAIL id_after_reset got=%h ok=%0b exp=dc000001", d, ok);
    end
  endtask

  initial begin
    test_reset();
    test_id_read();
    test_gpr_idx_reg();
    test_halt();
    test_gpr_read();
    test_rd_wait();
    test_resume_and_err();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/core_dbg_regs.md
Name: core_dbg_regs

Overview:
- Debug register file and core-control sequencer. Sits directly downstream of the core-debug APB slave and consumes its `core_dbg_req` / `wr_rd` / `addr` / `wdata` request stream.
- Returns read data with a one-cycle `core_dbg_rd_ready` pulse.
- Drives halt/resume/step handshakes and a GPR-access handshake into the CPU core.

Parameters:
- ADDR_WIDTH, 5, debug register address width (word index).
- DATA_WIDTH, 32, debug data width.
- GPR_IDX_WIDTH, 5, core GPR index width.
- TIMEOUT, 255, max cycles to wait for `gpr_ack` before flagging an error (8-bit counter).
- DBG_ID, 32'hDC00_0001, constant returned by the ID register.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- core_dbg_req  in  1  one-cycle request pulse from the APB slave.
- core_dbg_wr_rd  in  1  1 = write, 0 = read; valid with req.
- core_dbg_addr  in  ADDR_WIDTH  register index; valid with req.
- core_dbg_wdata  in  DATA_WIDTH  write data; valid with req.
- core_dbg_rdata  out  DATA_WIDTH  read data; valid while rd_ready = 1.
- core_dbg_rd_ready  out  1  one-cycle read-complete pulse.
- halt_req  out  1  level request to halt the core.
- resume_req  out  1  level request to resume the core.
- step_req  out  1  one-cycle single-step pulse.
- core_halted  in  1  core status: halted.
- gpr_req  out  1  GPR access request, held until ack.
- gpr_we  out  1  GPR access is a write.
- gpr_idx  out  GPR_IDX_WIDTH  GPR index.
- gpr_wdata  out  DATA_WIDTH  GPR write data.
- gpr_ack  in  1  one-cycle GPR access complete.
- gpr_rdata  in  DATA_WIDTH  GPR read data; valid with ack.

Behaviour:
- Reset values: all outputs 0; all registers 0; both FSMs idle.
- Register map (word index):
  - 0 CTRL (W): bit0 halt, bit1 resume, bit2 step. Reads as 0.
  - 1 STATUS (RO): bit0 core_halted, bit1 gpr_busy, bit2 gpr_err (sticky), bit3 sticky halted-seen.
  - 2 GPR_IDX (RW): [GPR_IDX_WIDTH-1:0].
  - 3 GPR_DATA (RW): written by the debugger or loaded from `gpr_rdata`.
  - 4 GPR_CMD (W): 1 = read GPR, 2 = write GPR, 3 = clear gpr_err and halted-seen.
  - 31 ID (RO): DBG_ID.
  - Unmapped reads return 0; unmapped writes are ignored.
- Write path: takes effect on the edge where req = 1 and wr_rd = 1. There is no response signal.
- Halt/resume:
  - halt bit sets `halt_req`; it stays 1 until `core_halted` = 1, then clears.
  - resume bit sets `resume_req` only if `core_halted` = 1; it stays 1 until `core_halted` = 0.
  - halt and resume written together: halt wins, resume is ignored.
  - step bit while halted: `step_req` pulses for 1 cycle. While not halted it is ignored.
- GPR FSM:
  - G_IDLE: on a CMD 1 or 2 write, if `core_halted` = 1, load `gpr_idx`/`gpr_we`/`gpr_wdata`, set `gpr_req` = 1, clear the counter, and go to G_WAIT. If not halted, set gpr_err and stay.
  - G_WAIT: on `gpr_ack`, drop req; for a read, load GPR_DATA with `gpr_rdata`; go to G_IDLE. If the counter reaches TIMEOUT, drop req, set gpr_err, go to G_IDLE.
  - gpr_busy = (state == G_WAIT).
  - A CMD write or GPR_DATA write while busy is ignored and sets gpr_err.
- Read FSM:
  - R_IDLE: on req with wr_rd = 0, latch addr. If the addr is GPR_DATA and gpr_busy, go to R_WAIT. Otherwise go to R_RESP.
  - R_WAIT: stay until not busy, then go to R_RESP. A timeout guarantees exit.
  - R_RESP: drive rdata, pulse rd_ready = 1 for exactly 1 cycle, return to R_IDLE. rdata returns to 0 the next cycle.
  - Latency: req seen at edge N → rd_ready high in cycle N+1, when not busy.
  - A new req while not in R_IDLE is dropped. The upstream protocol makes this illegal; the bench asserts it never happens.
- Simultaneous events:
  - `gpr_ack` and a GPR_DATA write in the same cycle: the ack load wins, and gpr_err is set.
  - `core_halted` falling during G_WAIT: the access continues.
- Reset mid-operation: reset wins in any state and immediately drops `gpr_req`, `halt_req`, `resume_req`.

Optional Feature:
- Macro: CORE_DBG_BKPT_EN.
- When defined:
  - Adds output port `bkpt_addr[DATA_WIDTH-1:0]` and output `bkpt_en`, plus input `bkpt_hit`.
  - Register 5 BKPT_ADDR (RW) drives `bkpt_addr`; bit0 of register 6 BKPT_CTRL (RW) drives `bkpt_en`.
  - `bkpt_hit` while `bkpt_en` = 1 asserts `halt_req` as a CTRL halt write does, and sets STATUS bit4 (sticky, cleared by CMD 3).
- When undefined: the ports are absent, registers 5 and 6 read 0 and ignore writes, and STATUS bit4 reads 0.

Test Plan:
- Read ID (addr 31) → rd_ready pulses one cycle after req, rdata = 32'hDC00_0001, then rd_ready = 0 and rdata = 0.
- Write CTRL = 1, core_halted rises 5 cycles later → halt_req high for exactly those cycles, then 0; STATUS read = 32'h9.
- While halted: write GPR_IDX = 7, CMD = 1; core acks after 3 cycles with gpr_rdata = 32'hCAFE_F00D → gpr_req high 3 cycles with gpr_idx = 7 and gpr_we = 0; GPR_DATA read = 32'hCAFE_F00D.
- Read GPR_DATA issued while gpr_busy, ack after 10 cycles → rd_ready withheld until the cycle after the ack, rdata = new value.
- CMD = 2 while not halted → gpr_req stays 0 and STATUS bit2 = 1. With halted and no ack → gpr_req drops after 255 cycles and gpr_err is set; CMD = 3 clears it.
- rst_n asserted during G_WAIT → all outputs 0 the next cycle; the subsequent ID read works normally.
